// File: rtl/stim_enable_scheduler.sv
// Paced round-robin read-enable scheduler: one strobe per slot, grouped into bursts separated by gaps.
// Latency: grant strobe appears the cycle after the slot edge; done pulses one cycle after the DONE state.
// Backpressure: a slot with no requesting channel is dropped; stop aborts to IDLE and wins over a coincident grant.
module stim_enable_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] repeat_time,
    input  logic [15:0]      burst_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [7:0]       n_bursts,
    input  logic [N_CH-1:0]  ch_req,
    output logic [N_CH-1:0]  ch_en,
    output logic             busy,
    output logic             done,
    output logic [15:0]      grant_cnt
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Pointer starts at the last channel so the first search begins at channel 0.
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  rep_m1;
    logic [15:0]       blen;
    logic [CNT_W-1:0]  glen;
    logic [7:0]        nb;
    logic [CNT_W-1:0]  div;
    logic [CNT_W-1:0]  gap_cnt;
    logic [15:0]       burst_grants;
    logic [7:0]        burst_cnt;
    logic [IDX_W-1:0]  ptr;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!win_vld && ch_req[(int'(ptr) + i) % N_CH]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(ptr) + i) % N_CH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rep_m1       <= '0;
            blen         <= '0;
            glen         <= '0;
            nb           <= '0;
            div          <= '0;
            gap_cnt      <= '0;
            burst_grants <= '0;
            burst_cnt    <= '0;
            ptr          <= PTR_INIT;
            ch_en        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            grant_cnt    <= '0;
        end else begin
            ch_en <= '0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        rep_m1       <= (repeat_time == '0) ? '0 : repeat_time - CNT_W'(1);
                        blen         <= burst_len;
                        glen         <= gap_len;
                        nb           <= n_bursts;
                        div          <= '0;
                        burst_grants <= '0;
                        burst_cnt    <= '0;
                        grant_cnt    <= '0;
                        ptr          <= PTR_INIT;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (div == rep_m1) begin
                        div <= '0;
                        if (win_vld) begin
                            ch_en     <= N_CH'(1) << win_idx;
                            ptr       <= win_idx;
                            grant_cnt <= grant_cnt + 16'd1;
                            if (blen != '0 && burst_grants + 16'd1 == blen) begin
                                burst_grants <= '0;
                                burst_cnt    <= burst_cnt + 8'd1;
                                if (nb != '0 && burst_cnt + 8'd1 == nb) begin
                                    busy  <= 1'b0;
                                    state <= DONE;
                                end else if (glen != '0) begin
                                    gap_cnt <= '0;
                                    state   <= GAP;
                                end
                            end else begin
                                burst_grants <= burst_grants + 16'd1;
                            end
                        end
                    end else begin
                        div <= div + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gap_cnt == glen - CNT_W'(1)) begin
                        div   <= '0;
                        state <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= !stop;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stim_enable_scheduler.sv
// Directed bench for stim_enable_scheduler: per-cycle strobe, done and count checks against hand-derived timelines.
module tb_stim_enable_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [9:0]  repeat_time, gap_len;
    logic [15:0] burst_len;
    logic [7:0]  n_bursts;
    logic [3:0]  ch_req;
    logic [3:0]  ch_en;
    logic        busy, done;
    logic [15:0] grant_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    stim_enable_scheduler #(.N_CH(4), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .repeat_time(repeat_time), .burst_len(burst_len), .gap_len(gap_len),
        .n_bursts(n_bursts), .ch_req(ch_req), .ch_en(ch_en), .busy(busy),
        .done(done), .grant_cnt(grant_cnt)
    );

    // Cycle 0 is the interval right after the edge that accepts start.
    task automatic start_sched(input logic [9:0] rt, input logic [15:0] bl,
                               input logic [9:0] gl, input logic [7:0] nbu);
        @(negedge clk);
        repeat_time = rt; burst_len = bl; gap_len = gl; n_bursts = nbu;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic stop_sched();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({ch_en, busy, done, grant_cnt} !== 22'd0) begin
            $display("FAIL reset_outputs: got ch_en=%b busy=%b done=%b grant_cnt=%0d, want all zero",
                     ch_en, busy, done, grant_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_single_burst();
        logic [3:0] exp_en;
        ch_req = 4'b0001;
        start_sched(10'd3, 16'd4, 10'd0, 8'd1);
        repeat_time = 10'd7;
        burst_len   = 16'd1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            exp_en = (c == 3 || c == 6 || c == 9 || c == 12) ? 4'b0001 : 4'b0000;
            chk_cnt++;
            if (ch_en !== exp_en) begin
                $display("FAIL single_en c%0d: got %b want %b", c, ch_en, exp_en);
            end else pass_cnt++;
            chk_cnt++;
            if (done !== (c == 13)) begin
                $display("FAIL single_done c%0d: got %b want %b", c, done, (c == 13));
            end else pass_cnt++;
            if (c == 5) begin
                chk_cnt++;
                if (busy !== 1'b1) begin
                    $display("FAIL single_busy c5: got %b want 1", busy);
                end else pass_cnt++;
            end
            if (c == 12) start = 1'b1;
            if (c == 13) start = 1'b0;
        end
        chk_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL single_idle_after_done: busy got %b want 0", busy);
        end else pass_cnt++;
        chk_cnt++;
        if (grant_cnt !== 16'd4) begin
            $display("FAIL single_grant_cnt: got %0d want 4", grant_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_en;
        for (int r = 0; r < 2; r++) begin
            ch_req = 4'b1111;
            start_sched(10'(r), 16'd0, 10'd0, 8'd0);
            for (int c = 0; c <= 5; c++) begin
                @(negedge clk);
                exp_en = (c == 0) ? 4'b0000 : (4'b0001 << ((c - 1) % 4));
                chk_cnt++;
                if (ch_en !== exp_en) begin
                    $display("FAIL rr_en rt%0d c%0d: got %b want %b", r, c, ch_en, exp_en);
                end else pass_cnt++;
            end
            stop = 1'b1;
            @(posedge clk);
            #1 stop = 1'b0;
            @(negedge clk);
            chk_cnt++;
            if ({ch_en, busy} !== 5'b0) begin
                $display("FAIL rr_stop rt%0d: got ch_en=%b busy=%b want 0", r, ch_en, busy);
            end else pass_cnt++;
            chk_cnt++;
            if (grant_cnt !== 16'd5) begin
                $display("FAIL rr_grant_cnt rt%0d: got %0d want 5", r, grant_cnt);
            end else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        logic [3:0] exp_en;
        ch_req = 4'b0101;
        start_sched(10'd2, 16'd2, 10'd5, 8'd2);
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            case (c)
                2, 11:   exp_en = 4'b0001;
                4, 13:   exp_en = 4'b0100;
                default: exp_en = 4'b0000;
            endcase
            chk_cnt++;
            if (ch_en !== exp_en) begin
                $display("FAIL gap_en c%0d: got %b want %b", c, ch_en, exp_en);
            end else pass_cnt++;
            chk_cnt++;
            if (done !== (c == 14)) begin
                $display("FAIL gap_done c%0d: got %b want %b", c, done, (c == 14));
            end else pass_cnt++;
            if (c == 7) begin
                chk_cnt++;
                if (busy !== 1'b1) begin
                    $display("FAIL gap_busy c7: got %b want 1", busy);
                end else pass_cnt++;
            end
        end
        chk_cnt++;
        if (grant_cnt !== 16'd4) begin
            $display("FAIL gap_grant_cnt: got %0d want 4", grant_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_empty_slots();
        logic [3:0] exp_en;
        ch_req = 4'b0000;
        start_sched(10'd2, 16'd0, 10'd0, 8'd0);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            exp_en = (c == 6) ? 4'b0010 : 4'b0000;
            chk_cnt++;
            if (ch_en !== exp_en) begin
                $display("FAIL empty_en c%0d: got %b want %b", c, ch_en, exp_en);
            end else pass_cnt++;
            if (c == 4) ch_req = 4'b0010;
        end
        stop_sched();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (grant_cnt !== 16'd1) begin
            $display("FAIL empty_grant_hold: got %0d want 1", grant_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_start_stop_idle();
        ch_req = 4'b1111;
        @(negedge clk);
        repeat_time = 10'd1; burst_len = 16'd0; n_bursts = 8'd0;
        start = 1'b1; stop = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; stop = 1'b0; end
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({busy, ch_en} !== 5'b0) begin
            $display("FAIL start_stop_idle: got busy=%b ch_en=%b want 0", busy, ch_en);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_gap();
        ch_req = 4'b0010;
        start_sched(10'd1, 16'd1, 10'd20, 8'd0);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (ch_en !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
                $display("FAIL midgap_en c%0d: got %b", c, ch_en);
            end else pass_cnt++;
        end
        chk_cnt++;
        if (busy !== 1'b1) begin
            $display("FAIL midgap_busy: got %b want 1", busy);
        end else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({ch_en, busy, done, grant_cnt} !== 22'd0) begin
            $display("FAIL midgap_async_reset: got ch_en=%b busy=%b done=%b grant_cnt=%0d want 0",
                     ch_en, busy, done, grant_cnt);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        ch_req = 4'b1111;
        start_sched(10'd1, 16'd0, 10'd0, 8'd0);
        @(negedge clk);
        chk_cnt++;
        if (grant_cnt !== 16'd0) begin
            $display("FAIL rerun_cnt_c0: got %0d want 0", grant_cnt);
        end else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (ch_en !== 4'b0001) begin
            $display("FAIL rerun_first_ch: got %b want 0001", ch_en);
        end else pass_cnt++;
        chk_cnt++;
        if (grant_cnt !== 16'd1) begin
            $display("FAIL rerun_cnt_c1: got %0d want 1", grant_cnt);
        end else pass_cnt++;
        stop_sched();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        repeat_time = '0; burst_len = '0; gap_len = '0; n_bursts = '0; ch_req = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_single_burst();
        test_round_robin();
        test_gaps();
        test_empty_slots();
        test_start_stop_idle();
        test_reset_mid_gap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
